univ_sreg: RTL

UNIV_SREG -- requirements
Module: univ_sreg

---
 rtl/univ_sreg_pkg.sv | 26 ++
 rtl/univ_sreg_ctrl.sv | 117 +++++++++++
 rtl/univ_sreg.sv | 102 ++++++++++
 3 files changed

// File: rtl/univ_sreg_pkg.sv
// Shared encodings for the universal shift register and its burst controller.
// Latency: n/a (types and a helper function only).
// Backpressure: n/a.
//
// mode_e  : per-cycle operation applied to q (hold / shift left / shift right / rotate left).
// state_e : burst controller states.
package univ_sreg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_ROTL = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // True when the operation moves data out of the MSB end (left shift and rotate).
    function automatic logic mode_exits_msb(mode_e m);
        return (m == MODE_SHL) || (m == MODE_ROTL);
    endfunction

endpackage

// File: rtl/univ_sreg_ctrl.sv
// Burst controller: FSM, remaining-operation counter, mode latch, busy and done.
// Latency: busy/done are registered; op_vld/eff_mode are combinational for the current edge.
// Backpressure: en low freezes FSM, counter and mode latch; no handshake otherwise.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en, sln           : clock enable, active-low synchronous load (aborts a burst)
//   start, nshift     : launch a burst of min(nshift, WIDTH) operations
//   mode              : requested operation (used directly while idle, latched at launch)
//   eff_mode          : operation the datapath should apply this edge
//   op_vld            : the datapath should apply eff_mode this edge (when en && sln)
//   busy, done        : burst active / one-cycle completion pulse
module univ_sreg_ctrl
    import univ_sreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sln,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] nshift,
    output logic [1:0]       eff_mode,
    output logic             op_vld,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            mode_lat_q, mode_lat_d;
    logic             done_q, done_d;

    mode_e            mode_in;
    logic [CNT_W-1:0] n_clip;
    logic             zero_start;

    assign mode_in    = mode_e'(mode);
    assign n_clip     = (nshift > WIDTH_C) ? WIDTH_C : nshift;
    assign zero_start = start && (nshift == '0);

    // Idle: free-running register follows the mode input, except a zero-length
    // launch which must leave q untouched. Shift: always apply the latched mode.
    assign op_vld   = (state_q == ST_SHIFT) || !zero_start;
    assign eff_mode = (state_q == ST_SHIFT) ? mode_lat_q : mode_in;
    assign busy     = (state_q == ST_SHIFT);
    assign done     = done_q;

    // cnt_q counts operations still to come after the current one, so the
    // launch edge loads min(nshift,WIDTH)-1 and the edge with cnt_q==1 is last.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_lat_d = mode_lat_q;
        done_d     = 1'b0;
        if (!en) begin
            // Frozen; done is a completion pulse and never survives a stalled edge.
            done_d = 1'b0;
        end else if (!sln) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (zero_start) begin
                            done_d = 1'b1;
                        end else begin
                            mode_lat_d = mode_in;
                            if (n_clip > ONE_C) begin
                                state_d = ST_SHIFT;
                                cnt_d   = n_clip - ONE_C;
                            end else begin
                                cnt_d  = '0;
                                done_d = 1'b1;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q <= ONE_C) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE_C;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mode_lat_q <= MODE_HOLD;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_lat_q <= mode_lat_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: rtl/univ_sreg.sv
// Universal shift register (hold/shl/shr/rotl) with counted-burst control.
// Latency: q updates on the edge after inputs are sampled; ser_out/par are combinational from q.
// Backpressure: en low freezes all state; no other flow control.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : clock enable
//   sln, sd         : active-low synchronous parallel load and its data
//   mode, ser_in    : operation select, serial fill bit
//   start, nshift   : launch a burst of min(nshift, WIDTH) operations
//   q, ser_out      : register contents, bit leaving q under the effective mode
//   busy, done      : burst active / one-cycle completion pulse
//   par             : XOR of q, present only when UNIV_SREG_PARITY_EN is defined
// WIDTH must be at least 2.
module univ_sreg
    import univ_sreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sln,
    input  logic [WIDTH-1:0] sd,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] nshift,
`ifdef UNIV_SREG_PARITY_EN
    output logic             par,
`endif
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       eff_mode_raw;
    mode_e            eff_mode;
    logic             op_vld;

    univ_sreg_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sln      (sln),
        .start    (start),
        .mode     (mode),
        .nshift   (nshift),
        .eff_mode (eff_mode_raw),
        .op_vld   (op_vld),
        .busy     (busy),
        .done     (done)
    );

    assign eff_mode = mode_e'(eff_mode_raw);

    always_comb begin
        q_d = q_q;
        if (en) begin
            if (!sln) begin
                q_d = sd;
            end else if (op_vld) begin
                case (eff_mode)
                    MODE_SHL:  q_d = {q_q[WIDTH-2:0], ser_in};
                    MODE_SHR:  q_d = {ser_in, q_q[WIDTH-1:1]};
                    MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    default:   q_d = q_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    always_comb begin
        ser_out = 1'b0;
        if (mode_exits_msb(eff_mode)) begin
            ser_out = q_q[WIDTH-1];
        end else if (eff_mode == MODE_SHR) begin
            ser_out = q_q[0];
        end
    end

    assign q = q_q;

`ifdef UNIV_SREG_PARITY_EN
    assign par = ^q_q;
`endif

endmodule
